// File: rtl/shift_rows_pipe.sv
// Rijndael ShiftRows / InvShiftRows feeding a 2-entry skid FIFO (1-cycle latency).
// Define SHIFT_ROWS_PIPE_INV_EN to honour in_inv; otherwise every block is forward-shifted.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:32*NB-1]  in_data,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:32*NB-1]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        occupancy
);
  localparam int W = 32 * NB;

  if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  // Rows 2 and 3 shift one further for the 256-bit block size.
  function automatic int row_off(input int r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  logic [0:W-1] fwd_data;
  logic [0:W-1] xf_data;

  always_comb begin
    fwd_data = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        fwd_data[8*(r+4*c) +: 8] = in_data[8*(r+4*((c+row_off(r)) % NB)) +: 8];
      end
    end
  end

`ifdef SHIFT_ROWS_PIPE_INV_EN
  logic [0:W-1] inv_data;

  always_comb begin
    inv_data = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        inv_data[8*(r+4*c) +: 8] = in_data[8*(r+4*((c-row_off(r)+NB) % NB)) +: 8];
      end
    end
  end

  assign xf_data = in_inv ? inv_data : fwd_data;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign xf_data       = fwd_data;
`endif

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // ready is a function of occupancy only, never of the partner's valid.
  logic [0:W-1]       data_q [2];
  logic [TAG_W-1:0]   tag_q  [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q, count_d;
  logic               push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = data_q[rd_ptr_q];
  assign out_tag   = tag_q[rd_ptr_q];
  assign occupancy = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= xf_data;
        tag_q[wr_ptr_q]  <= in_tag;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe: NB=4 and NB=8 instances, directed vectors.
module tb_shift_rows_pipe;
  localparam logic [0:127] V_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] V_FWD  = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [0:127] V_FIPS = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [0:127] V_FIPX = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [0:255] V8_SEQ = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:255] V8_FWD = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;
`ifdef SHIFT_ROWS_PIPE_INV_EN
  localparam logic [0:127] V_INVX = 128'h000d0a0704010e0b0805020f0c090603;
`else
  localparam logic [0:127] V_INVX = V_FWD;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b0;
  logic [0:127] in_data = '0;
  logic [3:0]   in_tag = '0;
  logic         in_ready, out_valid;
  logic [0:127] out_data;
  logic [3:0]   out_tag;
  logic [1:0]   occupancy;

  logic         in_valid8 = 1'b0, in_inv8 = 1'b0, out_ready8 = 1'b1;
  logic [0:255] in_data8 = '0;
  logic [3:0]   in_tag8 = '0;
  logic         in_ready8, out_valid8;
  logic [0:255] out_data8;
  logic [3:0]   out_tag8;
  logic [1:0]   occupancy8;

  logic [131:0] exp_q[$];
  logic [259:0] exp8_q[$];
  int n_cmp = 0;
  int n_err = 0;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .occupancy(occupancy)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_inv(in_inv8), .in_tag(in_tag8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .out_tag(out_tag8), .occupancy(occupancy8)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [259:0] act, input logic [259:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks: called just after a rising edge, return just after the accepting edge.
  task automatic send4(input logic [0:127] d, input logic inv, input logic [3:0] tag,
                       input logic [0:127] exp_d);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_inv = inv; in_tag = tag;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send4_timeout: in_ready stuck 0 for tag %0d", tag);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back({tag, exp_d});
    step();
    in_valid = 1'b0;
  endtask

  task automatic send8(input logic [0:255] d, input logic inv, input logic [3:0] tag,
                       input logic [0:255] exp_d);
    int t = 0;
    in_valid8 = 1'b1; in_data8 = d; in_inv8 = inv; in_tag8 = tag;
    while (!in_ready8 && t < 50) begin
      step();
      t++;
    end
    if (!in_ready8) begin
      n_cmp++; n_err++;
      $display("FAIL send8_timeout: in_ready stuck 0 for tag %0d", tag);
      in_valid8 = 1'b0;
      return;
    end
    exp8_q.push_back({tag, exp_d});
    step();
    in_valid8 = 1'b0;
  endtask

  // Monitors: compare each block as it is handed downstream; check holds while stalled.
  logic         hold_v = 1'b0;
  logic [131:0] hold_val;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        if (hold_v) chk("hold_stable", 260'({out_tag, out_data}), 260'(hold_val));
        hold_v   = 1'b1;
        hold_val = {out_tag, out_data};
      end else begin
        hold_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL out4_unexpected: got tag %0d data %0h, required none", out_tag, out_data);
        end else begin
          chk("out4", 260'({out_tag, out_data}), 260'(exp_q.pop_front()));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      if (exp8_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL out8_unexpected: got tag %0d data %0h, required none", out_tag8, out_data8);
      end else begin
        chk("out8", {out_tag8, out_data8}, exp8_q.pop_front());
      end
    end
  end

  initial begin
    int t;
    #1;
    chk("rst_occupancy", 260'(occupancy), 260'd0);
    chk("rst_in_ready",  260'(in_ready),  260'd1);
    chk("rst_out_valid", 260'(out_valid), 260'd0);
    chk("rst_out_data",  260'(out_data),  260'd0);
    chk("rst_out_tag",   260'(out_tag),   260'd0);
    #20;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Basic forward, latency of one edge
    send4(V_SEQ, 1'b0, 4'd5, V_FWD);
    chk("lat_out_valid", 260'(out_valid), 260'd1);
    chk("lat_occupancy", 260'(occupancy), 260'd1);
    step();

    send4(V_SEQ, 1'b1, 4'd6, V_INVX);
    send4(V_FIPS, 1'b0, 4'd7, V_FIPX);

    // Back-to-back throughput
    for (int i = 0; i < 4; i++) begin
      chk("tput_in_ready", 260'(in_ready), 260'd1);
      send4((i % 2 == 0) ? V_FIPS : V_SEQ, 1'b0, 4'(8 + i), (i % 2 == 0) ? V_FIPX : V_FWD);
    end
    step(); step();

    // Fill while stalled; third block must be refused
    out_ready = 1'b0;
    send4(V_FIPS, 1'b0, 4'd1, V_FIPX);
    send4(V_SEQ, 1'b0, 4'd2, V_FWD);
    in_valid = 1'b1; in_data = V_SEQ; in_tag = 4'd3; in_inv = 1'b0;
    step();
    chk("full_occupancy", 260'(occupancy), 260'd2);
    chk("full_in_ready",  260'(in_ready),  260'd0);
    chk("full_out_tag",   260'(out_tag),   260'd1);
    step();
    chk("full_occupancy2", 260'(occupancy), 260'd2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("drain_occupancy", 260'(occupancy), 260'd1);
    chk("drain_in_ready",  260'(in_ready),  260'd1);
    step();
    chk("drain_empty", 260'(occupancy), 260'd0);

    // Asynchronous reset with two blocks held
    out_ready = 1'b0;
    send4(V_SEQ, 1'b0, 4'd4, V_FWD);
    send4(V_FIPS, 1'b0, 4'd5, V_FIPX);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 260'(out_valid), 260'd0);
    chk("arst_occupancy", 260'(occupancy), 260'd0);
    chk("arst_in_ready",  260'(in_ready),  260'd1);
    chk("arst_out_data",  260'(out_data),  260'd0);
    exp_q.delete();
    exp8_q.delete();
    #10;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send4(V_FIPS, 1'b0, 4'd9, V_FIPX);

    // NB=8 path
    send8(V8_SEQ, 1'b0, 4'd1, V8_FWD);
`ifdef SHIFT_ROWS_PIPE_INV_EN
    send8(V8_FWD, 1'b1, 4'd2, V8_SEQ);
`else
    send8(V8_SEQ, 1'b1, 4'd2, V8_FWD);
`endif

    t = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0) && t < 50) begin
      step();
      t++;
    end
    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d/%0d blocks outstanding, required 0", exp_q.size(), exp8_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 SHALL have parameter NB, default 4, meaning state columns (Rijndael Nb); legal values 4, 6, 8; any other value SHALL fail elaboration.
REQ-002 SHALL have parameter TAG_W, default 4, meaning width of the sideband tag carried with each block.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream block valid.
REQ-006 SHALL have port in_ready  output  1  block accepted this cycle when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  32*NB, declared [0:32*NB-1]  state block; byte k = bits [8k+:8]; byte k holds row k%4, column k/4.
REQ-008 SHALL have port in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with in_data.
REQ-009 SHALL have port in_tag  input  TAG_W  sideband tag; sampled with in_data.
REQ-010 SHALL have port out_valid  output  1  output block valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-012 SHALL have port out_data  output  32*NB, declared [0:32*NB-1]  transformed block, same byte layout as in_data.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the block on out_data.
REQ-014 SHALL have port occupancy  output  2  number of held blocks, 0..2.

Function
REQ-015 Row offsets SHALL be: r0 = 0, r1 = 1, r2 = 2, r3 = 3 for NB 4 and 6; r0 = 0, r1 = 1, r2 = 3, r3 = 4 for NB 8.
REQ-016 Forward mode SHALL produce out(r,c) = in(r,(c+off_r) mod NB); inverse SHALL produce out(r,c) = in(r,(c-off_r+NB) mod NB).
REQ-017 Transform SHALL be applied before storage; each stored entry SHALL hold the transformed data and its tag; in_inv is not stored.
REQ-018 Storage SHALL be a 2-entry FIFO (skid buffer); blocks SHALL leave in acceptance order.
REQ-019 in_ready SHALL equal (occupancy != 2) and SHALL NOT depend combinationally on in_valid or out_ready.
REQ-020 out_valid SHALL equal (occupancy != 0); out_data/out_tag SHALL be the head entry.
REQ-021 Latency SHALL be 1 cycle: a block accepted at edge N into an empty buffer SHALL appear on out_data with out_valid = 1 after edge N.
REQ-022 While out_valid && !out_ready, out_data and out_tag SHALL stay stable.
REQ-023 Push and pop on the same edge SHALL leave occupancy unchanged; at occupancy 1 the new block becomes head after the pop.
REQ-024 At occupancy 2, in_ready = 0; a pop that edge SHALL drop occupancy to 1, with in_ready = 1 the following cycle.
REQ-025 Sustained in_valid = out_ready = 1 SHALL give one block per cycle throughput.
REQ-026 Write and read pointers SHALL be 1 bit each and wrap 1 -> 0.

Reset
REQ-027 While rst_n = 0: occupancy = 0, out_valid = 0, in_ready = 1, out_data = 0, out_tag = 0, both pointers 0, both entries cleared.
REQ-028 Reset asserted mid-operation SHALL discard all held blocks immediately, independent of clk.
REQ-029 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 With macro SHIFT_ROWS_PIPE_INV_EN defined, in_inv SHALL select the mode per REQ-016.
REQ-031 Without SHIFT_ROWS_PIPE_INV_EN, in_inv SHALL be ignored, every block SHALL use forward ShiftRows, and no inverse mux logic SHALL be synthesised.

Verification
REQ-032 NB=4, in_inv=0, in_data=00 01 .. 0f -> out_data = 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b, 1 cycle later.
REQ-033 NB=4, macro defined, in_inv=1, in_data=00..0f -> out_data = 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03.
REQ-034 NB=4, FIPS-197 round 1: d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, tag preserved.
REQ-035 out_ready = 0, push tags 1, 2, 3 -> occupancy 2, in_ready = 0, tag 3 not accepted, out_tag stays 1; then out_ready = 1 -> tags 1, 2 out in order.
REQ-036 NB=8, in_inv=0, in_data = bytes 00..1f -> column 0 = 00 05 0e 13, forward output followed by inverse returns 00..1f.
REQ-037 rst_n pulsed low mid-stream with occupancy 2 -> out_valid = 0 and occupancy = 0 before the next clk edge; in_ready = 1.
